cmp_pipe_n: RTL and testbench
=============================

// Module: cmp_pipe_n
// PURPOSE
//  Parametrised, pipelined magnitude/equality comparator; next generation of the 4-bit
//  subtract-and-invert-carry ULT. Computes I0-I1 through a carry chain split into CHUNK-bit
//  stages, one register stage per chunk. Supports 8 compare modes, signed and unsigned.
//  Uses a valid/ready stream interface. Sits between operand sources and control/branch logic.
// PARAMETERS
//  WIDTH   16  operand width in bits (>=2)
//  CHUNK    4  carry-chain bits per pipeline stage (1..WIDTH)
//  STAGES  derived = ceil(WIDTH/CHUNK); localparam, not overridable
// PORTS
//  CLK        in   1      clock, rising edge
//  RESETN     in   1      asynchronous active-low reset
//  IN_VALID   in   1      operand beat valid
//  IN_READY   out  1      block accepts beat this cycle
//  I0         in   WIDTH  left operand
//  I1         in   WIDTH  right operand
//  OP         in   3      compare mode: 0 EQ,1 NE,2 ULT,3 ULE,4 SLT,5 SLE,6 UGT,7 SGT
//  OUT_VALID  out  1      result valid
//  OUT_READY  in   1      consumer accepts result
//  O          out  1      compare result, 1 = true
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits and OUT_VALID = 0, O = 0.
//    Data regs need no reset. Reset mid-operation discards all in-flight beats.
//  - Global advance enable: ADV = !OUT_VALID | OUT_READY; IN_READY = ADV (combinational).
//  - Transfer on IN_VALID&IN_READY; result on OUT_VALID&OUT_READY. When ADV = 0, every stage holds.
//  - Latency: exactly STAGES cycles from accept to OUT_VALID, with no stalls. Throughput: 1 beat/cycle.
//  - Accept and emit in the same cycle is legal; bubbles (IN_VALID=0) propagate as invalid slots.
//  - Stage k (k=0..STAGES-1) adds chunk k of I0 and ~I1 with carry-in.
//    Stage 0 carry-in = 1; stage k carry-in = registered carry-out of stage k-1.
//  - Operand chunks not yet consumed, the OP code, and an AND-accumulated zero flag Z
//    (difference chunk == 0) travel with the beat.
//  - Last stage is WIDTH-CHUNK*(STAGES-1) bits wide when WIDTH%CHUNK != 0.
//  - Final flags: C = carry-out of MSB (1 => I0>=I1 unsigned); Z; N = diff MSB;
//    V = (I0[MSB]^I1[MSB]) & (I0[MSB]^N).
//  - Results: EQ=Z; NE=!Z; ULT=!C; ULE=!C|Z; SLT=N^V; SLE=(N^V)|Z; UGT=C&!Z; SGT=!(N^V)&!Z.
//  - O is registered in the output stage and is valid only while OUT_VALID=1.
//    O stays stable while OUT_VALID & !OUT_READY.
//  - Boundary cases: I0==I1 -> Z=1, C=1; 0 vs all-ones wraps correctly in signed modes.
//    CHUNK>=WIDTH gives a single stage, latency 1.
// CONFIGURATION
//  - CMP_MINMAX_EN defined: adds ports MIN, MAX (out, WIDTH each).
//    Both are registered with O and valid under OUT_VALID.
//    Signed ordering when OP[2]=1 and OP!=6, unsigned otherwise.
//    On equality, MIN = MAX = I0. Full operands are carried down the pipeline.
//    Reset value of MIN and MAX = 0.
//  - CMP_MINMAX_EN undefined: MIN/MAX ports absent and no operand copies are carried.
//    O timing is identical in both builds.
// TESTING
//  1 WIDTH=16,CHUNK=4: I0=3,I1=5,OP=ULT, OUT_READY=1 -> O=1 exactly 4 cycles after accept.
//  2 I0=16'hFFFF,I1=1: OP=SLT -> O=1; OP=ULT -> O=0.
//    I0=16'h8000,I1=16'h7FFF, OP=SGT -> O=0 (overflow case).
//  3 Back-to-back beats EQ(7,7), NE(7,7), ULE(9,9), UGT(0,0) with OUT_READY=1 ->
//    O = 1,0,1,0 on consecutive cycles, no bubbles.
//  4 Stream 6 beats, hold OUT_READY=0 for 3 cycles mid-stream -> IN_READY=0 while stalled,
//    O held stable, no beat lost or duplicated, order preserved.
//  5 Assert RESETN=0 with 3 beats in flight -> OUT_VALID=0 immediately, O=0.
//    After release, a new beat returns a correct result with full latency.
//  6 WIDTH=10,CHUNK=4 (ragged last stage) and WIDTH=8,CHUNK=8: sweep all 8 OPs over 256
//    random pairs -> every result matches the reference model.
//    With CMP_MINMAX_EN: SLT(-2,3) -> MIN=-2, MAX=3.

Source files
------------

// File: rtl/cmp_pipe_n.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pipe_n
//  Description : Parametrised pipelined magnitude/equality comparator.
//                I0 - I1 is formed as I0 + ~I1 + 1 on a carry chain cut into
//                CHUNK-bit slices, one register stage per slice. The final
//                slice derives the C/Z/N/V flags and selects one of eight
//                compare modes into a registered result O.
//  Parameters  : WIDTH (>=2) operand width, CHUNK (1..WIDTH) bits per stage.
//                STAGES = ceil(WIDTH/CHUNK) is derived, not overridable.
//  Ports       : clk        rising-edge clock
//                resetn     asynchronous active-low reset
//                in_valid   operand beat valid
//                in_ready   beat accepted this cycle (= global advance)
//                i0, i1     left / right operands
//                op         0 EQ,1 NE,2 ULT,3 ULE,4 SLT,5 SLE,6 UGT,7 SGT
//                out_valid  result valid
//                out_ready  consumer accepts result
//                o          compare result, 1 = true
//                min, max   (CMP_MINMAX_EN only) ordered operands
//  Build macro : CMP_MINMAX_EN - adds min/max outputs and carries full
//                operand copies down the pipeline. O timing is unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_pipe_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             o
`ifdef CMP_MINMAX_EN
    ,
    output logic [WIDTH-1:0] min,
    output logic [WIDTH-1:0] max
`endif
);

    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

    localparam logic [2:0] c_op_eq  = 3'd0;
    localparam logic [2:0] c_op_ne  = 3'd1;
    localparam logic [2:0] c_op_ult = 3'd2;
    localparam logic [2:0] c_op_ule = 3'd3;
    localparam logic [2:0] c_op_slt = 3'd4;
    localparam logic [2:0] c_op_sle = 3'd5;
    localparam logic [2:0] c_op_ugt = 3'd6;
    localparam logic [2:0] c_op_sgt = 3'd7;

    // Single advance enable: the whole pipe moves or the whole pipe holds.
    logic w_adv;
    logic r_out_valid;
    logic r_o;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        // c_rem: operand bits still unconsumed when the beat enters stage k.
        localparam int c_lo  = CHUNK * k;
        localparam int c_rem = WIDTH - c_lo;
        localparam int c_wk  = (k == STAGES - 1) ? c_rem : CHUNK;

        logic             w_vld_in;
        logic             w_cy_in;
        logic             w_z_in;
        logic [2:0]       w_op_in;
        logic [c_rem-1:0] w_a_in;
        logic [c_rem-1:0] w_b_in;
`ifdef CMP_MINMAX_EN
        logic [WIDTH-1:0] w_fa_in;
        logic [WIDTH-1:0] w_fb_in;
`endif
        logic [c_wk:0]    w_sum;
        logic [c_wk-1:0]  w_diff;
        logic             w_cy_out;
        logic             w_z_out;

        if (k == 0) begin : g_head
            // Subtraction as I0 + ~I1 + 1; zero flag starts true and is ANDed.
            assign w_vld_in = in_valid;
            assign w_cy_in  = 1'b1;
            assign w_z_in   = 1'b1;
            assign w_op_in  = op;
            assign w_a_in   = i0;
            assign w_b_in   = i1;
`ifdef CMP_MINMAX_EN
            assign w_fa_in  = i0;
            assign w_fb_in  = i1;
`endif
        end else begin : g_link
            assign w_vld_in = g_stage[k-1].g_reg.r_vld;
            assign w_cy_in  = g_stage[k-1].g_reg.r_cy;
            assign w_z_in   = g_stage[k-1].g_reg.r_z;
            assign w_op_in  = g_stage[k-1].g_reg.r_op;
            assign w_a_in   = g_stage[k-1].g_reg.r_a;
            assign w_b_in   = g_stage[k-1].g_reg.r_b;
`ifdef CMP_MINMAX_EN
            assign w_fa_in  = g_stage[k-1].g_reg.r_fa;
            assign w_fb_in  = g_stage[k-1].g_reg.r_fb;
`endif
        end

        assign w_sum    = {1'b0, w_a_in[c_wk-1:0]}
                        + {1'b0, ~w_b_in[c_wk-1:0]}
                        + {{c_wk{1'b0}}, w_cy_in};
        assign w_diff   = w_sum[c_wk-1:0];
        assign w_cy_out = w_sum[c_wk];
        assign w_z_out  = w_z_in && (w_diff == '0);

        if (k < STAGES - 1) begin : g_reg
            logic                  r_vld;
            logic                  r_cy;
            logic                  r_z;
            logic [2:0]            r_op;
            // Only the slices later stages still need travel with the beat.
            logic [c_rem-c_wk-1:0] r_a;
            logic [c_rem-c_wk-1:0] r_b;
`ifdef CMP_MINMAX_EN
            logic [WIDTH-1:0]      r_fa;
            logic [WIDTH-1:0]      r_fb;
`endif

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_vld <= 1'b0;
                end else if (w_adv) begin
                    r_vld <= w_vld_in;
                end
            end

            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_cy <= w_cy_out;
                    r_z  <= w_z_out;
                    r_op <= w_op_in;
                    r_a  <= w_a_in[c_rem-1:c_wk];
                    r_b  <= w_b_in[c_rem-1:c_wk];
`ifdef CMP_MINMAX_EN
                    r_fa <= w_fa_in;
                    r_fb <= w_fb_in;
`endif
                end
            end
        end else begin : g_tail
            logic w_c;
            logic w_z;
            logic w_n;
            logic w_v;
            logic w_slt;
            logic w_res;

            // Overflow: operands differ in sign and the result sign differs
            // from I0, so N alone no longer tells the signed ordering.
            assign w_c   = w_cy_out;
            assign w_z   = w_z_out;
            assign w_n   = w_diff[c_wk-1];
            assign w_v   = (w_a_in[c_wk-1] ^ w_b_in[c_wk-1]) & (w_a_in[c_wk-1] ^ w_n);
            assign w_slt = w_n ^ w_v;

            always_comb begin
                w_res = 1'b0;
                case (w_op_in)
                    c_op_eq:  w_res = w_z;
                    c_op_ne:  w_res = !w_z;
                    c_op_ult: w_res = !w_c;
                    c_op_ule: w_res = !w_c || w_z;
                    c_op_slt: w_res = w_slt;
                    c_op_sle: w_res = w_slt || w_z;
                    c_op_ugt: w_res = w_c && !w_z;
                    c_op_sgt: w_res = !w_slt && !w_z;
                    default:  w_res = 1'b0;
                endcase
            end

`ifdef CMP_MINMAX_EN
            logic             w_sgn;
            logic             w_lt;
            logic [WIDTH-1:0] w_mn;
            logic [WIDTH-1:0] w_mx;

            // UGT (6) is the one OP[2]=1 mode that orders unsigned.
            // On equality w_lt=0, so both outputs take I1 == I0.
            assign w_sgn = w_op_in[2] && (w_op_in != c_op_ugt);
            assign w_lt  = w_sgn ? w_slt : !w_c;
            assign w_mn  = w_lt ? w_fa_in : w_fb_in;
            assign w_mx  = w_lt ? w_fb_in : w_fa_in;
`endif
        end
    end

`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
`endif

    // Output stage; result fields only load on a real beat so O stays clean.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_o         <= 1'b0;
`ifdef CMP_MINMAX_EN
            r_min       <= '0;
            r_max       <= '0;
`endif
        end else if (w_adv) begin
            r_out_valid <= g_stage[STAGES-1].w_vld_in;
            if (g_stage[STAGES-1].w_vld_in) begin
                r_o   <= g_stage[STAGES-1].g_tail.w_res;
`ifdef CMP_MINMAX_EN
                r_min <= g_stage[STAGES-1].g_tail.w_mn;
                r_max <= g_stage[STAGES-1].g_tail.w_mx;
`endif
            end
        end
    end

    assign out_valid = r_out_valid;
    assign o         = r_o;
`ifdef CMP_MINMAX_EN
    assign min       = r_min;
    assign max       = r_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp_pipe_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_pipe_n
//  Description : Self-checking bench for cmp_pipe_n. Three instances cover
//                WIDTH/CHUNK = 16/4, 10/4 (ragged last stage) and 8/8 (single
//                stage). Expected results come from a table or from an
//                arithmetic reference model and are queued per instance,
//                then matched against the outputs in order.
//  Build macro : CMP_MINMAX_EN - also checks min/max outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_pipe_n;

    localparam int NI = 3;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        bit          o;
    } vec_t;

    typedef struct {
        bit          o;
        logic [15:0] mn;
        logic [15:0] mx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic        o         [NI];
    logic [15:0] a_in      [NI];
    logic [15:0] b_in      [NI];
    logic [2:0]  op_in     [NI];
    bit          exp_in    [NI];
    logic [15:0] mn        [NI];
    logic [15:0] mx        [NI];
    logic [9:0]  mn10, mx10;
    logic [7:0]  mn8,  mx8;

    exp_t sb [NI][$];
    vec_t tbl [15];
    int   n_vec = 0;
    int   n_err = 0;
    bit   rnd_rdy = 1'b0;

    always #5 clk = ~clk;

    cmp_pipe_n #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .resetn(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .i0(a_in[0]), .i1(b_in[0]), .op(op_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .o(o[0])
`ifdef CMP_MINMAX_EN
        , .min(mn[0]), .max(mx[0])
`endif
    );

    cmp_pipe_n #(.WIDTH(10), .CHUNK(4)) u_dut10 (
        .clk(clk), .resetn(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .i0(a_in[1][9:0]), .i1(b_in[1][9:0]), .op(op_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .o(o[1])
`ifdef CMP_MINMAX_EN
        , .min(mn10), .max(mx10)
`endif
    );

    cmp_pipe_n #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .resetn(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .i0(a_in[2][7:0]), .i1(b_in[2][7:0]), .op(op_in[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .o(o[2])
`ifdef CMP_MINMAX_EN
        , .min(mn8), .max(mx8)
`endif
    );

`ifndef CMP_MINMAX_EN
    assign mn[0] = 16'd0;
    assign mx[0] = 16'd0;
    assign mn10  = 10'd0;
    assign mx10  = 10'd0;
    assign mn8   = 8'd0;
    assign mx8   = 8'd0;
`endif
    assign mn[1] = {6'd0, mn10};
    assign mx[1] = {6'd0, mx10};
    assign mn[2] = {8'd0, mn8};
    assign mx[2] = {8'd0, mx8};

    // ------------------------------------------------------------ model
    function automatic int wid(int i);
        case (i)
            0:       return 16;
            1:       return 10;
            default: return 8;
        endcase
    endfunction

    function automatic int stg(int i);
        case (i)
            0:       return 4;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic longint uval(logic [15:0] x, int w);
        longint m = (longint'(1) << w) - 1;
        return longint'({48'd0, x}) & m;
    endfunction

    function automatic longint sval(logic [15:0] x, int w);
        longint u = uval(x, w);
        if (u >= (longint'(1) << (w - 1))) return u - (longint'(1) << w);
        return u;
    endfunction

    function automatic bit ref_cmp(logic [15:0] a, logic [15:0] b, logic [2:0] op, int w);
        longint ua = uval(a, w), ub = uval(b, w);
        longint sa = sval(a, w), sb_ = sval(b, w);
        case (op)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd2:    return ua <  ub;
            3'd3:    return ua <= ub;
            3'd4:    return sa <  sb_;
            3'd5:    return sa <= sb_;
            3'd6:    return ua >  ub;
            default: return sa >  sb_;
        endcase
    endfunction

    function automatic exp_t ref_item(bit e, logic [15:0] a, logic [15:0] b,
                                      logic [2:0] op, int w);
        exp_t   r;
        bit     sgn = op[2] && (op != 3'd6);
        longint ua = uval(a, w), ub = uval(b, w);
        bit     lt = sgn ? (sval(a, w) < sval(b, w)) : (ua < ub);
        r.o  = e;
        r.mn = 16'(lt ? ua : ub);
        r.mx = 16'(lt ? ub : ua);
        return r;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(string nm, int i, longint got, longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) sb[i].delete();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (out_valid[i]) begin
                    if (sb[i].size() == 0) begin
                        chk("unexpected_result", i, 1, 0);
                    end else begin
                        chk("o", i, longint'(o[i]), longint'(sb[i][0].o));
`ifdef CMP_MINMAX_EN
                        chk("min", i, longint'(mn[i]), longint'(sb[i][0].mn));
                        chk("max", i, longint'(mx[i]), longint'(sb[i][0].mx));
`endif
                        if (out_ready[i]) void'(sb[i].pop_front());
                    end
                end
                if (in_valid[i] && in_ready[i])
                    sb[i].push_back(ref_item(exp_in[i], a_in[i], b_in[i], op_in[i], wid(i)));
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready[0] = ($urandom_range(0, 3) != 0);
        end
    end

    // ----------------------------------------------------------- tasks
    task automatic drive_beat(int i, logic [15:0] a, logic [15:0] b, logic [2:0] op, bit e);
        int t   = 0;
        bit acc = 1'b0;
        in_valid[i] = 1'b1;
        a_in[i]     = a;
        b_in[i]     = b;
        op_in[i]    = op;
        exp_in[i]   = e;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = in_ready[i];
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk("accept_timeout", i, 0, 1);
    endtask

    task automatic latency_check(int i, logic [15:0] a, logic [15:0] b, logic [2:0] op,
                                 bit e, int exp_lat);
        int lat = 1;
        drive_beat(i, a, b, op, e);
        in_valid[i] = 1'b0;
        while (!out_valid[i] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", i, lat, exp_lat);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        int t = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        for (int i = 0; i < NI; i++) chk("drain", i, sb[i].size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ main
    initial begin
        logic [15:0] a, b;
        logic [2:0]  op;

        tbl[0]  = '{16'hFFFF, 16'h0001, 3'd4, 1'b1};
        tbl[1]  = '{16'hFFFF, 16'h0001, 3'd2, 1'b0};
        tbl[2]  = '{16'h8000, 16'h7FFF, 3'd7, 1'b0};
        tbl[3]  = '{16'h8000, 16'h7FFF, 3'd4, 1'b1};
        tbl[4]  = '{16'h7FFF, 16'h8000, 3'd5, 1'b0};
        tbl[5]  = '{16'h0000, 16'hFFFF, 3'd4, 1'b0};
        tbl[6]  = '{16'h0000, 16'hFFFF, 3'd2, 1'b1};
        tbl[7]  = '{16'hFFFF, 16'h0000, 3'd7, 1'b0};
        tbl[8]  = '{16'h0005, 16'h0003, 3'd6, 1'b1};
        tbl[9]  = '{16'h1234, 16'h1234, 3'd5, 1'b1};
        tbl[10] = '{16'h1234, 16'h1234, 3'd3, 1'b1};
        tbl[11] = '{16'h1234, 16'h1234, 3'd1, 1'b0};
        tbl[12] = '{16'hFFFE, 16'h0003, 3'd4, 1'b1};
        tbl[13] = '{16'h0010, 16'h000F, 3'd3, 1'b0};
        tbl[14] = '{16'hF000, 16'h0FFF, 3'd7, 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            a_in[i]      = '0;
            b_in[i]      = '0;
            op_in[i]     = '0;
            exp_in[i]    = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_out_valid", i, longint'(out_valid[i]), 0);
            chk("rst_o",         i, longint'(o[i]), 0);
            chk("rst_in_ready",  i, longint'(in_ready[i]), 1);
`ifdef CMP_MINMAX_EN
            chk("rst_min", i, longint'(mn[i]), 0);
            chk("rst_max", i, longint'(mx[i]), 0);
`endif
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency 3 ULT 5 on every geometry
        for (int i = 0; i < NI; i++) latency_check(i, 16'd3, 16'd5, 3'd2, 1'b1, stg(i));

        // Table vectors, back to back
        foreach (tbl[n]) drive_beat(0, tbl[n].a, tbl[n].b, tbl[n].op, tbl[n].o);
        in_valid[0] = 1'b0;
        wait_empty();

        // Back-to-back EQ/NE/ULE/UGT: results 1,0,1,0 with no bubbles
        drive_beat(0, 16'd7, 16'd7, 3'd0, 1'b1);
        drive_beat(0, 16'd7, 16'd7, 3'd1, 1'b0);
        drive_beat(0, 16'd9, 16'd9, 3'd3, 1'b1);
        drive_beat(0, 16'd0, 16'd0, 3'd6, 1'b0);
        in_valid[0] = 1'b0;
        for (int t = 0; t < 10 && !out_valid[0]; t++) begin
            @(posedge clk);
            #1;
        end
        chk("b2b_first_valid", 0, longint'(out_valid[0]), 1);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            chk("no_bubble", 0, longint'(out_valid[0]), 1);
        end
        wait_empty();

        // Stall mid-stream: 5 beats, hold consumer 3 cycles with beat 6 pending
        for (int n = 0; n < 5; n++) begin
            a  = rnd16();
            b  = rnd16();
            op = 3'($urandom_range(0, 7));
            drive_beat(0, a, b, op, ref_cmp(a, b, op, 16));
        end
        out_ready[0] = 1'b0;
        a  = 16'h8001;
        b  = 16'h0002;
        op = 3'd4;
        in_valid[0] = 1'b1;
        a_in[0]     = a;
        b_in[0]     = b;
        op_in[0]    = op;
        exp_in[0]   = ref_cmp(a, b, op, 16);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall_in_ready", 0, longint'(in_ready[0]), 0);
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        drive_beat(0, a, b, op, ref_cmp(a, b, op, 16));
        in_valid[0] = 1'b0;
        wait_empty();

        // Reset with beats in flight and a held result at the output
        out_ready[0] = 1'b0;
        drive_beat(0, 16'h0001, 16'h0001, 3'd0, 1'b1);
        drive_beat(0, 16'h0002, 16'h0001, 3'd6, 1'b1);
        drive_beat(0, 16'h0003, 16'h0004, 3'd2, 1'b1);
        drive_beat(0, 16'h0004, 16'h0004, 3'd1, 1'b0);
        in_valid[0] = 1'b0;
        chk("pre_reset_valid", 0, longint'(out_valid[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_out_valid", 0, longint'(out_valid[0]), 0);
        chk("reset_o",         0, longint'(o[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        latency_check(0, 16'h1234, 16'h1235, 3'd3, 1'b1, 4);

        // Random traffic with bubbles and random back-pressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid[0] = 1'b0;
                @(posedge clk);
                #1;
            end
            a  = rnd16();
            b  = ($urandom_range(0, 5) == 0) ? a : rnd16();
            op = 3'($urandom_range(0, 7));
            drive_beat(0, a, b, op, ref_cmp(a, b, op, 16));
        end
        in_valid[0] = 1'b0;
        rnd_rdy     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        wait_empty();

        // Ragged and single-stage geometries: every OP over 256 random pairs
        for (int i = 1; i < NI; i++) begin
            for (int p = 0; p < 256; p++) begin
                a = rnd16();
                b = ($urandom_range(0, 7) == 0) ? a : rnd16();
                for (int k = 0; k < 8; k++)
                    drive_beat(i, a, b, 3'(k), ref_cmp(a, b, 3'(k), wid(i)));
            end
            in_valid[i] = 1'b0;
            wait_empty();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
